// File: rtl/imul_mul_arbiter_pkg.sv
// Shared widths, requester id type and round-robin pointer helpers for the
// multiplier arbiter slice.
package imul_arb_pkg;

    localparam int IMUL_REQ_NBITS  = 64;
    localparam int IMUL_RESP_NBITS = 32;

    typedef logic [2:0] imul_req_id_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } imul_req_msg_t;

    // base + step, wrapped into 0..nreqs-1 (step < nreqs)
    function automatic imul_req_id_t rr_advance(imul_req_id_t base, int step, int nreqs);
        int sum;
        sum = int'({29'd0, base}) + step;
        if (sum >= nreqs) begin
            sum = sum - nreqs;
        end
        return imul_req_id_t'(sum);
    endfunction

    function automatic imul_req_id_t rr_next(imul_req_id_t grant, int nreqs);
        return rr_advance(grant, 1, nreqs);
    endfunction

endpackage

// File: rtl/imul_mul_arbiter_if.sv
// Client-side and multiplier-side handshake bundle of the multiplier arbiter.
// slave = arbiter view, master = environment (clients + multiplier) view.
interface imul_mul_arbiter_if #(
    parameter int p_nreqs = 4
);
    import imul_arb_pkg::*;

    logic [p_nreqs-1:0]                in_req_val;
    logic [p_nreqs-1:0]                in_req_rdy;
    logic [IMUL_REQ_NBITS*p_nreqs-1:0] in_req_msg;

    logic [p_nreqs-1:0]                in_resp_val;
    logic [p_nreqs-1:0]                in_resp_rdy;
    logic [IMUL_RESP_NBITS-1:0]        in_resp_msg;

    logic                              mul_req_val;
    logic                              mul_req_rdy;
    logic [IMUL_REQ_NBITS-1:0]         mul_req_msg;

    logic                              mul_resp_val;
    logic                              mul_resp_rdy;
    logic [IMUL_RESP_NBITS-1:0]        mul_resp_msg;

    logic [2:0]                        inflight;

    modport slave (
        input  in_req_val, in_req_msg, in_resp_rdy,
        input  mul_req_rdy, mul_resp_val, mul_resp_msg,
        output in_req_rdy, in_resp_val, in_resp_msg,
        output mul_req_val, mul_req_msg, mul_resp_rdy, inflight
    );

    modport master (
        output in_req_val, in_req_msg, in_resp_rdy,
        output mul_req_rdy, mul_resp_val, mul_resp_msg,
        input  in_req_rdy, in_resp_val, in_resp_msg,
        input  mul_req_val, mul_req_msg, mul_resp_rdy, inflight
    );

endinterface

// File: rtl/imul_mul_arbiter_tag_queue.sv
// In-order FIFO of requester ids for transactions outstanding in the multiplier.
// Latency: push visible at head the cycle after; pop takes effect at the next edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates both.
module imul_arb_tag_queue
    import imul_arb_pkg::*;
#(
    parameter int p_depth = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  imul_req_id_t push_id,
    input  logic         pop,
    output imul_req_id_t head_id,
    output logic         full,
    output logic         empty,
    output logic [2:0]   count
);

    localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;

    imul_req_id_t  mem [p_depth];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
        return (p == PW'(p_depth - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == 3'(p_depth));
    assign empty   = (count == 3'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_id = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

endmodule

// File: rtl/imul_mul_arbiter.sv
// Round-robin share of one val/rdy multiplier among p_nreqs clients, with tag-routed responses.
// Latency: 0 cycles on both request and response paths (pure combinational muxing).
// Backpressure: tag queue full blocks grants; a stalled response owner stalls the multiplier.
module imul_mul_arbiter
    import imul_arb_pkg::*;
#(
    parameter int p_nreqs = 4,
    parameter int p_ntags = 2
) (
    input logic               clk,
    input logic               reset,
    imul_mul_arbiter_if.slave bus
);

    imul_req_id_t              rr_ptr;
    imul_req_id_t              grant;
    imul_req_id_t              head;
    logic                      any_val;
    logic                      tq_full;
    logic                      tq_empty;
    logic                      req_ok;
    logic                      req_fire;
    logic                      resp_ok;
    logic                      resp_fire;
    logic                      head_rdy;
    logic [2*p_nreqs-1:0]      val_rot;
    logic [IMUL_REQ_NBITS-1:0] grant_msg;

    // Rotate the valid vector so bit k is requester rr_ptr+k; lowest k wins.
    assign any_val = |bus.in_req_val;
    assign val_rot = {bus.in_req_val, bus.in_req_val} >> rr_ptr;

    always_comb begin
        grant = rr_ptr;
        for (int k = p_nreqs - 1; k >= 0; k--) begin
            if (val_rot[k]) begin
                grant = rr_advance(rr_ptr, k, p_nreqs);
            end
        end
    end

    always_comb begin
        grant_msg = '0;
        for (int i = 0; i < p_nreqs; i++) begin
            if (grant == imul_req_id_t'(i)) begin
                grant_msg = bus.in_req_msg[IMUL_REQ_NBITS*i +: IMUL_REQ_NBITS];
            end
        end
    end

    // Full uses registered occupancy only, so a same-cycle pop never frees a slot.
    assign req_ok          = reset && any_val && !tq_full;
    assign req_fire        = req_ok && bus.mul_req_rdy;
    assign bus.mul_req_val = req_ok;
    assign bus.mul_req_msg = grant_msg;

    always_comb begin
        bus.in_req_rdy = '0;
        for (int i = 0; i < p_nreqs; i++) begin
            bus.in_req_rdy[i] = req_fire && (grant == imul_req_id_t'(i));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (req_fire) begin
            rr_ptr <= rr_next(grant, p_nreqs);
        end
    end

    // Response demux: the queue head names the owner of the product in flight.
    assign resp_ok = reset && !tq_empty && bus.mul_resp_val;

    always_comb begin
        head_rdy        = 1'b0;
        bus.in_resp_val = '0;
        for (int i = 0; i < p_nreqs; i++) begin
            if (head == imul_req_id_t'(i)) begin
                head_rdy           = bus.in_resp_rdy[i];
                bus.in_resp_val[i] = resp_ok;
            end
        end
    end

    assign bus.mul_resp_rdy = reset && !tq_empty && head_rdy;
    assign resp_fire        = bus.mul_resp_val && bus.mul_resp_rdy;
    assign bus.in_resp_msg  = bus.mul_resp_msg;

    imul_arb_tag_queue #(
        .p_depth (p_ntags)
    ) u_tag_queue (
        .clk     (clk),
        .reset   (reset),
        .push    (req_fire),
        .push_id (grant),
        .pop     (resp_fire),
        .head_id (head),
        .full    (tq_full),
        .empty   (tq_empty),
        .count   (bus.inflight)
    );

    // A product with no outstanding tag has no owner to route to.
    a_resp_needs_tag: assert property (@(posedge clk) disable iff (!reset)
        !(bus.mul_resp_val && tq_empty))
        else $error("mul_resp_val asserted with empty tag queue");

endmodule

// File: tb/tb_imul_mul_arbiter.sv
module tb_imul_mul_arbiter;

    localparam int NR = 4;
    localparam int NT = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;

    imul_mul_arbiter_if #(.p_nreqs(NR)) bus ();

    imul_mul_arbiter #(
        .p_nreqs (NR),
        .p_ntags (NT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stimulus state: per-client pending requests, behavioural multiplier queue.
    logic [63:0] src_q [NR][$];
    logic [31:0] mul_q [$];
    logic [NR-1:0] src_en;
    logic [NR-1:0] snk_rdy;
    logic mul_rdy_en;
    logic mul_resp_en;
    bit   rand_mode;

    // Reference model: round-robin pointer, owner queue, per-client expected products.
    int          mdl_rr;
    int          mdl_tq [$];
    logic [31:0] exp_q [NR][$];

    // Handshakes observed in the compare window, applied at the next edge.
    bit          m_push;
    bit          m_pop;
    int          m_grant;
    logic [NR-1:0] f_src;
    logic [NR-1:0] f_snk;
    logic        f_mreq;
    logic        f_mresp;
    logic [63:0] f_mreq_msg;

    int n_chk;
    int n_pass;
    int resp_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        end
        return (mdl_tq.size() == 0) && (mul_q.size() == 0);
    endfunction

    // Drive inputs just after the falling edge.
    always @(negedge clk) begin
        if (rand_mode) begin
            for (int i = 0; i < NR; i++) begin
                src_en[i]  = ($urandom_range(0, 3) != 0);
                snk_rdy[i] = ($urandom_range(0, 3) != 0);
            end
            mul_rdy_en  = ($urandom_range(0, 3) != 0);
            mul_resp_en = ($urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < NR; i++) begin
            bus.in_req_val[i] = src_en[i] && (src_q[i].size() > 0);
            bus.in_req_msg[64*i +: 64] = (src_q[i].size() > 0) ? src_q[i][0] : 64'd0;
        end
        bus.in_resp_rdy  = snk_rdy;
        bus.mul_req_rdy  = mul_rdy_en;
        bus.mul_resp_val = mul_resp_en && (mul_q.size() > 0);
        bus.mul_resp_msg = (mul_q.size() > 0) ? mul_q[0] : 32'd0;
    end

    // Compare DUT outputs against the model once inputs have settled.
    always @(negedge clk) begin
        #3;
        m_push = 1'b0;
        m_pop  = 1'b0;
        f_src  = '0;
        f_snk  = '0;
        f_mreq = 1'b0;
        f_mresp = 1'b0;
        f_mreq_msg = '0;
        if (!reset) begin
            chk("rst_in_req_rdy", bus.in_req_rdy, 0);
            chk("rst_mul_req_val", bus.mul_req_val, 0);
            chk("rst_in_resp_val", bus.in_resp_val, 0);
            chk("rst_mul_resp_rdy", bus.mul_resp_rdy, 0);
            chk("rst_inflight", bus.inflight, 0);
        end else begin
            int g;
            int head;
            bit full;
            bit e_val;
            bit e_mrdy;
            logic [63:0] e_rdy;
            logic [63:0] e_rval;
            g = -1;
            for (int k = 0; k < NR; k++) begin
                if (g < 0 && bus.in_req_val[(mdl_rr + k) % NR]) g = (mdl_rr + k) % NR;
            end
            full  = (mdl_tq.size() == NT);
            e_val = (g >= 0) && !full;
            e_rdy = (e_val && bus.mul_req_rdy) ? (64'd1 << g) : 64'd0;
            chk("mul_req_val", bus.mul_req_val, e_val);
            chk("in_req_rdy", bus.in_req_rdy, e_rdy);
            if (e_val) chk("mul_req_msg", bus.mul_req_msg, src_q[g][0]);

            head   = (mdl_tq.size() > 0) ? mdl_tq[0] : -1;
            e_rval = (head >= 0 && bus.mul_resp_val) ? (64'd1 << head) : 64'd0;
            e_mrdy = (head >= 0) && bus.in_resp_rdy[head];
            chk("in_resp_val", bus.in_resp_val, e_rval);
            chk("mul_resp_rdy", bus.mul_resp_rdy, e_mrdy);
            chk("in_resp_msg", bus.in_resp_msg, bus.mul_resp_msg);
            chk("inflight", bus.inflight, mdl_tq.size());

            m_push  = e_val && bus.mul_req_rdy;
            m_grant = g;
            m_pop   = (head >= 0) && bus.mul_resp_val && e_mrdy;

            f_src      = bus.in_req_val & bus.in_req_rdy;
            f_snk      = bus.in_resp_val & bus.in_resp_rdy;
            f_mreq     = bus.mul_req_val && bus.mul_req_rdy;
            f_mreq_msg = bus.mul_req_msg;
            f_mresp    = bus.mul_resp_val && bus.mul_resp_rdy;
            for (int i = 0; i < NR; i++) begin
                if (f_snk[i]) begin
                    chk("resp_owner_pending", exp_q[i].size() != 0, 1);
                    if (exp_q[i].size() != 0) chk("resp_product", bus.in_resp_msg, exp_q[i][0]);
                end
            end
        end
    end

    // Advance model and stimulus state on the active edge.
    always @(posedge clk) begin
        if (!reset) begin
            mdl_rr = 0;
            mdl_tq.delete();
            mul_q.delete();
            for (int i = 0; i < NR; i++) exp_q[i].delete();
        end else begin
            logic [63:0] m;
            if (m_pop) void'(mdl_tq.pop_front());
            if (m_push) begin
                mdl_tq.push_back(m_grant);
                mdl_rr = (m_grant + 1) % NR;
            end
            for (int i = 0; i < NR; i++) begin
                if (f_snk[i] && exp_q[i].size() != 0) begin
                    void'(exp_q[i].pop_front());
                    resp_cnt++;
                end
                if (f_src[i]) begin
                    m = src_q[i][0];
                    exp_q[i].push_back(m[63:32] * m[31:0]);
                    void'(src_q[i].pop_front());
                end
            end
            if (f_mresp && mul_q.size() != 0) void'(mul_q.pop_front());
            if (f_mreq) mul_q.push_back(f_mreq_msg[63:32] * f_mreq_msg[31:0]);
        end
    end

    task automatic peek();
        @(negedge clk);
        #4;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        bit done;
        done = all_idle();
        for (int k = 0; k < budget && !done; k++) begin
            @(posedge clk);
            #1;
            done = all_idle();
        end
        chk(name, done, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        n_chk = 0; n_pass = 0; resp_cnt = 0;
        mdl_rr = 0;
        src_en = '1; snk_rdy = '1; mul_rdy_en = 1'b1; mul_resp_en = 1'b1; rand_mode = 1'b0;
        bus.in_req_val = '0; bus.in_req_msg = '0; bus.in_resp_rdy = '0;
        bus.mul_req_rdy = 1'b0; bus.mul_resp_val = 1'b0; bus.mul_resp_msg = '0;

        // Reset state with a request already presented
        src_q[0].push_back({32'd3, 32'd5});
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_req_rdy", bus.in_req_rdy, 0);
        chk("reset_mul_req_val", bus.mul_req_val, 0);
        chk("reset_inflight", bus.inflight, 0);
        reset = 1'b1;

        // 1: single client, 3*5
        peek();
        chk("t1_mul_req_val", bus.mul_req_val, 1);
        chk("t1_mul_req_msg", bus.mul_req_msg, 64'h0000_0003_0000_0005);
        chk("t1_in_req_rdy", bus.in_req_rdy, 4'b0001);
        peek();
        chk("t1_resp_val", bus.in_resp_val, 4'b0001);
        chk("t1_resp_msg", bus.in_resp_msg, 32'd15);
        chk("t1_inflight", bus.inflight, 1);
        chk("t1_model_rr", mdl_rr, 1);
        peek();
        chk("t1_inflight_after", bus.inflight, 0);
        chk("t1_rr_ptr", dut.rr_ptr, 1);
        chk("t1_resp_val_after", bus.in_resp_val, 0);

        // 2: all clients valid, grant order 0,1,2,3,0,1,2,3
        do_reset();
        for (int i = 0; i < NR; i++) begin
            src_q[i].push_back({32'(i + 5), 32'(i + 4)});
            src_q[i].push_back({32'(i + 10), 32'd3});
        end
        for (int c = 0; c < 8; c++) begin
            peek();
            chk($sformatf("t2_grant_c%0d", c), bus.in_req_rdy, 64'd1 << (c % NR));
            if (c == 3) begin
                chk("t2_resp2_val", bus.in_resp_val, 4'b0100);
                chk("t2_resp2_msg", bus.in_resp_msg, 32'd42);
            end
        end
        drain("t2_drain", 50);

        // 3: full tag queue blocks grants, including the cycle of a pop
        do_reset();
        mul_resp_en = 1'b0;
        src_q[0].push_back({32'd2, 32'd9});
        src_q[1].push_back({32'd4, 32'd4});
        src_q[2].push_back({32'd6, 32'd7});
        peek();
        peek();
        peek();
        chk("t3_inflight_full", bus.inflight, 2);
        chk("t3_rdy_full", bus.in_req_rdy, 0);
        chk("t3_mreq_full", bus.mul_req_val, 0);
        mul_resp_en = 1'b1;
        peek();
        chk("t3_pop_resp_val", bus.in_resp_val, 4'b0001);
        chk("t3_pop_resp_msg", bus.in_resp_msg, 32'd18);
        chk("t3_pop_mul_resp_rdy", bus.mul_resp_rdy, 1);
        chk("t3_pop_no_grant", bus.in_req_rdy, 0);
        chk("t3_pop_no_mreq", bus.mul_req_val, 0);
        peek();
        chk("t3_grant_next", bus.in_req_rdy, 4'b0100);
        chk("t3_inflight_next", bus.inflight, 1);
        drain("t3_drain", 50);

        // 4: owner backpressure holds the product
        do_reset();
        snk_rdy[1] = 1'b0;
        base = resp_cnt;
        src_q[1].push_back({32'h7FFF_FFFF, 32'd2});
        peek();
        for (int c = 1; c <= 10; c++) begin
            peek();
            chk("t4_hold_val", bus.in_resp_val, 4'b0010);
            chk("t4_hold_mrdy", bus.mul_resp_rdy, 0);
            chk("t4_hold_msg", bus.in_resp_msg, 32'hFFFF_FFFE);
        end
        snk_rdy[1] = 1'b1;
        peek();
        chk("t4_release_val", bus.in_resp_val, 4'b0010);
        chk("t4_release_mrdy", bus.mul_resp_rdy, 1);
        peek();
        chk("t4_after_val", bus.in_resp_val, 0);
        chk("t4_after_inflight", bus.inflight, 0);
        chk("t4_delivered_once", resp_cnt - base, 1);

        // 5: asynchronous reset with two transactions outstanding
        do_reset();
        mul_resp_en = 1'b0;
        for (int i = 0; i < NR; i++) src_q[i].push_back({32'(i + 1), 32'd100});
        peek();
        peek();
        peek();
        chk("t5_inflight_before", bus.inflight, 2);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("t5_rst_in_req_rdy", bus.in_req_rdy, 0);
        chk("t5_rst_mul_req_val", bus.mul_req_val, 0);
        chk("t5_rst_inflight", bus.inflight, 0);
        chk("t5_rst_mul_resp_rdy", bus.mul_resp_rdy, 0);
        mul_resp_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("t5_rr_ptr", dut.rr_ptr, 0);
        chk("t5_inflight", bus.inflight, 0);
        chk("t5_model_rr", mdl_rr, 0);
        peek();
        chk("t5_first_grant", bus.in_req_rdy, 4'b0100);
        drain("t5_drain", 50);

        // 6: random stress
        do_reset();
        base = resp_cnt;
        for (int i = 0; i < NR; i++) begin
            for (int n = 0; n < 1000; n++) src_q[i].push_back({$urandom(), $urandom()});
        end
        rand_mode = 1'b1;
        drain("t6_drain", 60000);
        rand_mode = 1'b0;
        chk("t6_resp_count", resp_cnt - base, NR * 1000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
